bp_stall_prof_ctrl: RTL

- Synthesizable controller for a per-core stall-reason counter bank.
- Consumes the per-cycle stall classification from the core profiling pipeline: one encoded reason code per non-retiring cycle, plus an instret flag.
- Sequences the counter bank through start, stop, timed-window, clear-sweep and snapshot operations.
- Serves host reads from a shadow (snapshot) bank over a valid/ready port, so counts can be read without disturbing live counting.

---
 rtl/bp_stall_prof_ctrl_if.sv | 27 ++
 rtl/bp_stall_prof_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_stall_prof_ctrl_if.sv
// Host-side command and read port of the stall-reason profiler controller.
// The master modport is the host; the slave modport is the controller.
interface bp_stall_prof_ctrl_if #(
   parameter int cnt_width_p    = 32,
   parameter int reason_width_p = 5
);
   logic                      cmd_v_i;
   logic [1:0]                cmd_i;
   logic [cnt_width_p-1:0]    cmd_window_i;
   logic                      cmd_ready_o;
   logic                      rd_v_i;
   logic [reason_width_p-1:0] rd_addr_i;
   logic                      rd_ready_o;
   logic                      rd_v_o;
   logic [cnt_width_p-1:0]    rd_data_o;
   logic                      rd_yumi_i;

   modport master (
      output cmd_v_i, cmd_i, cmd_window_i, rd_v_i, rd_addr_i, rd_yumi_i,
      input  cmd_ready_o, rd_ready_o, rd_v_o, rd_data_o
   );

   modport slave (
      input  cmd_v_i, cmd_i, cmd_window_i, rd_v_i, rd_addr_i, rd_yumi_i,
      output cmd_ready_o, rd_ready_o, rd_v_o, rd_data_o
   );
endinterface

// File: rtl/bp_stall_prof_ctrl.sv
// Stall-reason counter bank controller: live counting, timed windows, clear sweep,
// snapshot to a shadow bank and host reads. Optional BP_STALL_PROF_OVERFLOW_EN adds ovf_o.
//
// state | meaning
// IDLE  | counters hold, commands accepted
// RUN   | counting enabled (when not frozen), optional window countdown
// CLEAR | sweeping one live counter per cycle, commands blocked
module bp_stall_prof_ctrl #(
   parameter int num_reasons_p  = 24,
   parameter int cnt_width_p    = 32,
   parameter int reason_width_p = 5
) (
   input  logic                      clk_i,
   input  logic                      reset_li,
   input  logic                      freeze_i,
   input  logic                      stall_v_i,
   input  logic [reason_width_p-1:0] stall_reason_i,
   input  logic                      instret_i,
   bp_stall_prof_ctrl_if.slave       bus,
   output logic [1:0]                state_o
`ifdef BP_STALL_PROF_OVERFLOW_EN
   ,
   output logic                      ovf_o
`endif
);

   localparam int num_cnt_lp = num_reasons_p + 2;
   localparam logic [reason_width_p-1:0] reasons_lp     = reason_width_p'(num_reasons_p);
   localparam logic [reason_width_p-1:0] instret_idx_lp = reason_width_p'(num_reasons_p);
   localparam logic [reason_width_p-1:0] cycles_idx_lp  = reason_width_p'(num_reasons_p + 1);
   localparam logic [reason_width_p-1:0] ovf_addr_lp    = reason_width_p'(num_reasons_p + 2);

   localparam logic [1:0] state_idle_lp  = 2'd0;
   localparam logic [1:0] state_run_lp   = 2'd1;
   localparam logic [1:0] state_clear_lp = 2'd2;

   localparam logic [1:0] cmd_start_lp = 2'd0;
   localparam logic [1:0] cmd_stop_lp  = 2'd1;
   localparam logic [1:0] cmd_clear_lp = 2'd2;
   localparam logic [1:0] cmd_snap_lp  = 2'd3;

   logic [1:0]                r_state;
   logic [1:0]                w_state_n;
   logic [cnt_width_p-1:0]    r_live   [num_cnt_lp];
   logic [cnt_width_p-1:0]    r_shadow [num_cnt_lp];
   logic [cnt_width_p-1:0]    r_window;
   logic [cnt_width_p-1:0]    w_window_n;
   logic                      r_auto_snap;
   logic [reason_width_p-1:0] r_clr_idx;
   logic                      r_rd_v;
   logic [cnt_width_p-1:0]    r_rd_data;

   logic                      w_cmd_ready;
   logic                      w_cmd_acc;
   logic                      w_count_en;
   logic                      w_win_expire;
   logic                      w_clear_start;
   logic                      w_snap_cmd;
   logic                      w_snap;
   logic                      w_rd_ready;
   logic                      w_rd_acc;
   logic [cnt_width_p-1:0]    w_rd_data;
   logic [reason_width_p-1:0] w_reason_idx;
   logic [num_cnt_lp-1:0]     w_inc;

   assign w_cmd_ready = (r_state != state_clear_lp);
   assign w_cmd_acc   = bus.cmd_v_i & w_cmd_ready;
   assign w_count_en  = (r_state == state_run_lp) & ~freeze_i;
   assign w_win_expire = w_count_en & (r_window == cnt_width_p'(1));
   assign w_snap      = w_snap_cmd | r_auto_snap;
   assign w_rd_ready  = ~r_rd_v | bus.rd_yumi_i;
   assign w_rd_acc    = bus.rd_v_i & w_rd_ready;

   assign bus.cmd_ready_o = w_cmd_ready;
   assign bus.rd_ready_o  = w_rd_ready;
   assign bus.rd_v_o      = r_rd_v;
   assign bus.rd_data_o   = r_rd_data;
   assign state_o         = r_state;

   // Out-of-range reason codes are folded into the "unknown" counter.
   always_comb begin
      w_reason_idx = (stall_reason_i >= reasons_lp) ? '0 : stall_reason_i;
      w_inc = '0;
      if (w_count_en) begin
         w_inc[cycles_idx_lp] = 1'b1;
         if (instret_i)
            w_inc[instret_idx_lp] = 1'b1;
         else if (stall_v_i)
            w_inc[w_reason_idx] = 1'b1;
      end
   end

   always_comb begin
      w_state_n     = r_state;
      w_window_n    = r_window;
      w_clear_start = 1'b0;
      w_snap_cmd    = 1'b0;
      if (w_count_en && (r_window != '0))
         w_window_n = r_window - cnt_width_p'(1);
      if (w_win_expire)
         w_state_n = state_idle_lp;
      if (w_cmd_acc) begin
         case (bus.cmd_i)
            cmd_start_lp: begin
               w_state_n  = state_run_lp;
               w_window_n = bus.cmd_window_i;
            end
            cmd_stop_lp:  w_state_n = state_idle_lp;
            cmd_clear_lp: begin
               w_state_n     = state_clear_lp;
               w_clear_start = 1'b1;
            end
            default:      w_snap_cmd = 1'b1;
         endcase
      end
      if ((r_state == state_clear_lp) && (r_clr_idx == cycles_idx_lp))
         w_state_n = state_idle_lp;
   end

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         r_state     <= state_idle_lp;
         r_window    <= '0;
         r_auto_snap <= 1'b0;
         r_clr_idx   <= '0;
      end else begin
         r_state     <= w_state_n;
         r_window    <= w_window_n;
         r_auto_snap <= w_win_expire;
         if (w_clear_start)
            r_clr_idx <= '0;
         else if (r_state == state_clear_lp)
            r_clr_idx <= r_clr_idx + reason_width_p'(1);
      end
   end

   // The shadow copy uses pre-edge live values, so a same-cycle event is excluded.
   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         for (int i = 0; i < num_cnt_lp; i++) begin
            r_live[i]   <= '0;
            r_shadow[i] <= '0;
         end
      end else begin
         for (int i = 0; i < num_cnt_lp; i++) begin
            if ((r_state == state_clear_lp) && (r_clr_idx == reason_width_p'(i)))
               r_live[i] <= '0;
            else if (w_inc[i] && (r_live[i] != '1))
               r_live[i] <= r_live[i] + cnt_width_p'(1);
            if (w_snap)
               r_shadow[i] <= r_live[i];
         end
      end
   end

`ifdef BP_STALL_PROF_OVERFLOW_EN
   logic                      r_ovf;
   logic [reason_width_p-1:0] r_ovf_idx;
   logic [num_cnt_lp-1:0]     w_ovf_hit;
   logic [reason_width_p-1:0] w_ovf_first;

   // Lowest index wins when several counters saturate in the same cycle.
   always_comb begin
      w_ovf_first = '0;
      for (int i = 0; i < num_cnt_lp; i++)
         w_ovf_hit[i] = w_inc[i] & (r_live[i] == '1);
      for (int i = num_cnt_lp - 1; i >= 0; i--)
         if (w_ovf_hit[i])
            w_ovf_first = reason_width_p'(i);
   end

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         r_ovf     <= 1'b0;
         r_ovf_idx <= '0;
      end else if (w_clear_start) begin
         r_ovf     <= 1'b0;
      end else if (!r_ovf && (|w_ovf_hit)) begin
         r_ovf     <= 1'b1;
         r_ovf_idx <= w_ovf_first;
      end
   end

   assign ovf_o = r_ovf;

   always_comb begin
      w_rd_data = '0;
      if (bus.rd_addr_i < ovf_addr_lp)
         w_rd_data = r_shadow[bus.rd_addr_i];
      else if ((bus.rd_addr_i == ovf_addr_lp) && r_ovf)
         w_rd_data = cnt_width_p'(r_ovf_idx);
   end
`else
   always_comb begin
      w_rd_data = '0;
      if (bus.rd_addr_i < ovf_addr_lp)
         w_rd_data = r_shadow[bus.rd_addr_i];
   end
`endif

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         r_rd_v    <= 1'b0;
         r_rd_data <= '0;
      end else if (w_rd_acc) begin
         r_rd_v    <= 1'b1;
         r_rd_data <= w_rd_data;
      end else if (bus.rd_yumi_i) begin
         r_rd_v    <= 1'b0;
      end
   end

endmodule
